seg7_scan_driver: RTL and testbench

Time-multiplexed seven-segment display driver that sits directly downstream of the lab counter: it consumes the counter's 4-bit `count` value, alongside other nibbles, and drives the board's common-anode digit array. It captures a multi-digit hex value once per scan frame, which prevents tearing. It then cycles through the digits with a programmable refresh slot and inserts a blanking gap at every digit change to suppress ghosting. All outputs are active-low and registered.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_scan_driver_if.sv | 35 +++
 rtl/seg7_scan_driver_hex_to_seg7.sv | 12 +
 rtl/seg7_scan_driver.sv | 138 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and hex decode for the seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n holds the glyph for hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg7(
    input logic [3:0] nibble
  );
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle: captured digit data in, multiplexed drive out.
// The driver uses the slave view; the upstream/board side uses master.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   digit_en;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;
  logic                dp;
  logic                frame_start;

  modport master (
    output value,
    output dp_in,
    output digit_en,
    input  an,
    input  seg,
    input  dp,
    input  frame_start
  );

  modport slave (
    input  value,
    input  dp_in,
    input  digit_en,
    output an,
    output seg,
    output dp,
    output frame_start
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
// Single shared decoder; the caller muxes the nibble in.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = seg7_pkg::hex_to_seg7(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-frame
// capture, blanking gap between digits and optional leading-zero blank.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 16,
  parameter int BLANK_CYCLES = 4,
  parameter int LZ_BLANK     = 0
) (
  input logic mainClock,
  input logic reset,
  seg7_scan_driver_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [IW-1:0] IDX_LAST =
    IW'(DIGITS - 1);

  localparam logic [REFRESH_BITS-1:0] BLANK_P =
    REFRESH_BITS'(BLANK_CYCLES);

  localparam logic [DIGITS-1:0] ONE_HOT0 =
    DIGITS'(1);

  generate
    if (DIGITS < 2 || DIGITS > 8) begin : gBadDigits
      $error("DIGITS must be in 2..8");
    end
    if (BLANK_CYCLES < 1 ||
        BLANK_CYCLES >= (1 << REFRESH_BITS)) begin : gBadBlank
      $error("BLANK_CYCLES out of range");
    end
  endgenerate

  logic [REFRESH_BITS-1:0] p;
  logic [REFRESH_BITS-1:0] pNext;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           idxNext;
  logic                    frameWrap;

  logic [4*DIGITS-1:0] shValue;
  logic [4*DIGITS-1:0] shValueNext;
  logic [DIGITS-1:0]   shDp;
  logic [DIGITS-1:0]   shDpNext;
  logic [DIGITS-1:0]   shEn;
  logic [DIGITS-1:0]   shEnNext;

  logic [3:0]        nibble;
  logic [6:0]        decSeg;
  logic              showNext;
  logic              leadZero;
  logic [DIGITS-1:0] anNext;
  logic [6:0]        segNext;
  logic              dpNext;

  logic [DIGITS-1:0] anQ;
  logic [6:0]        segQ;
  logic              dpQ;
  logic              frameStartQ;

  always_comb begin
    pNext     = p + 1'b1;
    idxNext   = idx;
    frameWrap = 1'b0;
    if (p == '1) begin
      if (idx == IDX_LAST) begin
        idxNext   = '0;
        frameWrap = 1'b1;
      end else begin
        idxNext = idx + 1'b1;
      end
    end
  end

  // Capture only at frame wrap so a frame never mixes two values
  assign shValueNext = frameWrap ? bus.value    : shValue;
  assign shDpNext    = frameWrap ? bus.dp_in    : shDp;
  assign shEnNext    = frameWrap ? bus.digit_en : shEn;

  assign nibble = shValueNext[{idxNext, 2'b00} +: 4];

  hex_to_seg7 uDecode (
    .nibble   (nibble),
    .segments (decSeg)
  );

  assign showNext = (pNext >= BLANK_P);

  // Digit and everything above it zero; digit 0 always shown
  assign leadZero = (LZ_BLANK != 0) &&
                    (idxNext != '0) &&
                    ((shValueNext >> {idxNext, 2'b00}) == '0);

  always_comb begin
    anNext  = '1;
    segNext = SEG_BLANK;
    dpNext  = 1'b1;
    if (showNext) begin
      if (shEnNext[idxNext]) begin
        anNext = ~(ONE_HOT0 << idxNext);
      end
      segNext = leadZero ? SEG_BLANK : decSeg;
      dpNext  = ~shDpNext[idxNext];
    end
  end

  always_ff @(posedge mainClock or posedge reset) begin
    if (reset) begin
      p           <= '0;
      idx         <= '0;
      shValue     <= '0;
      shDp        <= '0;
      shEn        <= '0;
      anQ         <= '1;
      segQ        <= SEG_BLANK;
      dpQ         <= 1'b1;
      frameStartQ <= 1'b0;
    end else begin
      p           <= pNext;
      idx         <= idxNext;
      shValue     <= shValueNext;
      shDp        <= shDpNext;
      shEn        <= shEnNext;
      anQ         <= anNext;
      segQ        <= segNext;
      dpQ         <= dpNext;
      frameStartQ <= frameWrap;
    end
  end

  assign bus.an          = anQ;
  assign bus.seg         = segQ;
  assign bus.dp          = dpQ;
  assign bus.frame_start = frameStartQ;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised bench for seg7_scan_driver: two instances (plain and
// leading-zero blanking) checked every cycle against a time-based model.
module tb_seg7_scan_driver;

  localparam int FRAME = 32;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;

  logic mainClock = 1'b0;
  logic reset     = 1'b1;

  logic [15:0] value   = '0;
  logic [3:0]  dpIn    = '0;
  logic [3:0]  digitEn = '0;

  seg7_scan_driver_if #(.DIGITS(4)) bus0 ();
  seg7_scan_driver_if #(.DIGITS(4)) bus1 ();

  assign bus0.value    = value;
  assign bus0.dp_in    = dpIn;
  assign bus0.digit_en = digitEn;
  assign bus1.value    = value;
  assign bus1.dp_in    = dpIn;
  assign bus1.digit_en = digitEn;

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_BITS(3),
    .BLANK_CYCLES(2), .LZ_BLANK(0)
  ) dut0 (
    .mainClock (mainClock),
    .reset     (reset),
    .bus       (bus0)
  );

  seg7_scan_driver #(
    .DIGITS(4), .REFRESH_BITS(3),
    .BLANK_CYCLES(2), .LZ_BLANK(1)
  ) dut1 (
    .mainClock (mainClock),
    .reset     (reset),
    .bus       (bus1)
  );

  always #5 mainClock = ~mainClock;

  logic [6:0] segTab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  int nChecks = 0;
  int nErrors = 0;

  // Model: cycles since reset release plus the frame's captured inputs
  int          t    = 0;
  logic [15:0] mVal = '0;
  logic [3:0]  mDp  = '0;
  logic [3:0]  mEn  = '0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s @%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic modelReset();
    t    = 0;
    mVal = '0;
    mDp  = '0;
    mEn  = '0;
  endtask

  task automatic checkDut(
    input string      who,
    input bit         lz,
    input logic [3:0] an,
    input logic [6:0] seg,
    input logic       dp,
    input logic       fs
  );
    int         pos;
    int         d;
    int         ph;
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;
    logic       eFs;
    pos  = t % FRAME;
    d    = pos / SLOT;
    ph   = pos % SLOT;
    eAn  = 4'hF;
    eSeg = 7'h7F;
    eDp  = 1'b1;
    if (ph >= BLANK) begin
      if (mEn[d]) eAn = ~(4'(1) << d);
      eSeg = segTab[mVal[4*d +: 4]];
      if (lz && d > 0 && (mVal >> (4*d)) == 0)
        eSeg = 7'h7F;
      eDp = ~mDp[d];
    end
    eFs = (pos == 0 && t > 0);
    chk({who, ".an"}, 32'(an), 32'(eAn));
    chk({who, ".seg"}, 32'(seg), 32'(eSeg));
    chk({who, ".dp"}, 32'(dp), 32'(eDp));
    chk({who, ".fs"}, 32'(fs), 32'(eFs));
    chk({who, ".onehot"},
        32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic checkAll();
    checkDut("d0", 1'b0, bus0.an, bus0.seg,
             bus0.dp, bus0.frame_start);
    checkDut("d1", 1'b1, bus1.an, bus1.seg,
             bus1.dp, bus1.frame_start);
  endtask

  task automatic step();
    @(posedge mainClock);
    if (reset) begin
      modelReset();
    end else begin
      t++;
      if (t % FRAME == 0) begin
        mVal = value;
        mDp  = dpIn;
        mEn  = digitEn;
      end
    end
    #1;
    checkAll();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic releaseAndFindFrame();
    int first;
    first = 0;
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus0.frame_start === 1'b1 && first == 0)
        first = k;
    end
    chk("fs_first", 32'(first), 32'd32);
  endtask

  initial begin
    modelReset();
    run(3);
    releaseAndFindFrame();

    // Scan order and mid-frame capture
    value   = 16'h1234;
    digitEn = 4'hF;
    dpIn    = 4'h0;
    while (t % FRAME != 0) step();
    run(FRAME);
    while (t % FRAME != 12) step();
    value = 16'hABCD;
    run(FRAME + 24);

    // Anode masking and decimal point
    value   = 16'h8888;
    digitEn = 4'b0101;
    dpIn    = 4'b0001;
    run(2 * FRAME);

    // Leading zeros
    value   = 16'h0050;
    digitEn = 4'hF;
    dpIn    = 4'h0;
    run(2 * FRAME);
    value = 16'h0000;
    run(2 * FRAME);

    // Random inputs changing at random points within frames
    for (int f = 0; f < 10; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        step();
        if ($urandom_range(0, 7) == 0) begin
          value   = 16'($urandom);
          dpIn    = 4'($urandom);
          digitEn = 4'($urandom);
        end
      end
    end

    // Asynchronous reset in the middle of a lit SHOW phase
    value   = 16'h1234;
    digitEn = 4'hF;
    run(FRAME);
    while (t % SLOT != 4) step();
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkAll();
    chk("rst_an", 32'(bus0.an), 32'hF);
    chk("rst_seg", 32'(bus0.seg), 32'h7F);
    chk("rst_dp", 32'(bus0.dp), 32'd1);
    run(2);
    releaseAndFindFrame();
    run(FRAME);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
